// File: rtl/uart_dac_frame_router.sv
// uart_dac_frame_router: parses framed UART bytes into DAC words, routes
// them to per-channel FIFOs and answers each frame with ACK/NAK/status.
// Ports: clk, reset_n (async, active low); rx_data/rx_valid byte input;
//   fifo_full in, fifo_wr_en/fifo_wr_data out (per-channel FIFO writes);
//   tx_data/tx_valid reply out, tx_busy in; frame_err pulse; overflow sticky.
// Optional build macro ROUTER_CHECKSUM_EN: trailing XOR checksum byte.
module uart_dac_frame_router #(
  parameter int DACN           = 2,
  parameter int DATA_W         = 24,
  parameter int BYTES_PER_WORD = 3,
  parameter int TIMEOUT_CLKS   = 2600
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [DACN-1:0]   fifo_full,
  output logic [DACN-1:0]   fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic              frame_err,
  output logic [DACN-1:0]   overflow
);

  localparam int PW = 8 * BYTES_PER_WORD;
`ifdef ROUTER_CHECKSUM_EN
  localparam int NB = BYTES_PER_WORD + 1;
`else
  localparam int NB = BYTES_PER_WORD;
`endif
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [7:0]    ACK      = 8'h06;
  localparam logic [7:0]    NAK      = 8'h15;
  localparam logic [7:0]    LAST     = 8'(NB - 1);
  localparam logic [7:0]    NPAY     = 8'(BYTES_PER_WORD);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_HEADER,
    S_PAYLOAD,
    S_DISCARD,
    S_COMMIT,
    S_RESPOND
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_payload;
  logic [7:0]      r_cnt;
  logic [TW-1:0]   r_tmo;
  logic [7:0]      r_skid;
  logic            r_skid_v;
  logic            r_bcast;
  logic [5:0]      r_chan;
  logic [7:0]      r_reply;
`ifdef ROUTER_CHECKSUM_EN
  logic [7:0]      r_csum;
  logic            r_csum_ok;
`endif

  logic            w_parse;
  logic            w_take;
  logic [7:0]      w_byte;
  logic [PW-1:0]   w_next_pay;
  logic [7:0]      w_status;
  logic            w_chan_ok;
  logic [DACN-1:0] w_tgt;
  logic [DACN-1:0] w_hit_full;
  logic            w_drop;
  logic            w_ok;
  logic            w_tmo_hit;

  // The skid byte is always older than a byte arriving this cycle,
  // so the parser drains it first.
  assign w_parse    = (r_state == S_HEADER) || (r_state == S_PAYLOAD) ||
                      (r_state == S_DISCARD);
  assign w_take     = w_parse && (r_skid_v || rx_valid);
  assign w_byte     = r_skid_v ? r_skid : rx_data;
  assign w_next_pay = PW'({r_payload, w_byte});
  assign w_status   = 8'(fifo_full);
  assign w_chan_ok  = ({1'b0, w_byte[5:0]} < 7'(DACN));
  assign w_tmo_hit  = (r_tmo == TMO_LAST);

  always_comb begin
    w_tgt = '0;
    for (int i = 0; i < DACN; i++) begin
      w_tgt[i] = r_bcast || (r_chan == 6'(i));
    end
  end

  assign w_hit_full = w_tgt & fifo_full;
  assign w_drop     = |w_hit_full;

`ifdef ROUTER_CHECKSUM_EN
  assign w_ok = r_csum_ok;
`else
  assign w_ok = 1'b1;
`endif

  // Write strobes follow the live full flags during the COMMIT cycle.
  assign fifo_wr_en   = (r_state == S_COMMIT && w_ok) ?
                        (w_tgt & ~fifo_full) : '0;
  assign fifo_wr_data = (r_state == S_COMMIT) ?
                        r_payload[DATA_W-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_HEADER;
      r_payload <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_skid    <= '0;
      r_skid_v  <= 1'b0;
      r_bcast   <= 1'b0;
      r_chan    <= '0;
      r_reply   <= '0;
`ifdef ROUTER_CHECKSUM_EN
      r_csum    <= '0;
      r_csum_ok <= 1'b0;
`endif
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= '0;
    end else begin
      tx_valid  <= 1'b0;
      frame_err <= 1'b0;

      if (w_parse) begin
        if (r_skid_v) begin
          r_skid_v <= rx_valid;
          if (rx_valid) r_skid <= rx_data;
        end
      end else if (rx_valid) begin
        if (r_skid_v) begin
          frame_err <= 1'b1;
        end else begin
          r_skid   <= rx_data;
          r_skid_v <= 1'b1;
        end
      end

      unique case (r_state)
        S_HEADER: begin
          if (w_take) begin
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_bcast <= (w_byte[7:6] == 2'b01);
            r_chan  <= w_byte[5:0];
`ifdef ROUTER_CHECKSUM_EN
            r_csum  <= w_byte;
`endif
            unique case (w_byte[7:6])
              2'b00: r_state <= w_chan_ok ? S_PAYLOAD : S_DISCARD;
              2'b01: r_state <= S_PAYLOAD;
              2'b10: begin
                r_reply <= w_status;
                r_state <= S_RESPOND;
              end
              default: r_state <= S_DISCARD;
            endcase
          end
        end

        S_PAYLOAD: begin
          if (w_take) begin
            r_tmo <= '0;
            if (r_cnt < NPAY) begin
              r_payload <= w_next_pay;
`ifdef ROUTER_CHECKSUM_EN
              r_csum    <= r_csum ^ w_byte;
            end else begin
              r_csum_ok <= (r_csum == w_byte);
`endif
            end
            if (r_cnt == LAST) r_state <= S_COMMIT;
            else               r_cnt   <= r_cnt + 8'd1;
          end else if (w_tmo_hit) begin
            frame_err <= 1'b1;
            r_state   <= S_HEADER;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        S_DISCARD: begin
          if (w_take) begin
            r_tmo <= '0;
            if (r_cnt == LAST) begin
              r_reply   <= NAK;
              frame_err <= 1'b1;
              r_state   <= S_RESPOND;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else if (w_tmo_hit) begin
            frame_err <= 1'b1;
            r_state   <= S_HEADER;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        S_COMMIT: begin
          if (w_ok) overflow <= overflow | w_hit_full;
          if (!w_ok || w_drop) begin
            r_reply   <= NAK;
            frame_err <= 1'b1;
          end else begin
            r_reply <= ACK;
          end
          r_state <= S_RESPOND;
        end

        S_RESPOND: begin
          if (!tx_busy) begin
            tx_valid <= 1'b1;
            tx_data  <= r_reply;
            r_state  <= S_HEADER;
          end
        end

        default: r_state <= S_HEADER;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dac_frame_router.sv
// tb_uart_dac_frame_router: randomized and directed frames against a
// frame-level reference model of the router.
module tb_uart_dac_frame_router;

  localparam int DACN = 2;
  localparam int DW   = 24;
  localparam int BPW  = 3;
  localparam int TMO  = 2600;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [7:0]      rx_data = '0;
  logic            rx_valid = 1'b0;
  logic [DACN-1:0] fifo_full = '0;
  logic [DACN-1:0] fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_busy = 1'b0;
  logic            frame_err;
  logic [DACN-1:0] overflow;

  uart_dac_frame_router #(
    .DACN(DACN), .DATA_W(DW),
    .BYTES_PER_WORD(BPW), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_busy(tx_busy), .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int last_cyc = 0;

  logic [DACN-1:0] o_mask[$];
  logic [DW-1:0]   o_data[$];
  int              o_cyc[$];
  logic [7:0]      o_tx[$];
  int              o_err = 0;

  logic [DACN-1:0] e_mask[$];
  logic [DW-1:0]   e_data[$];
  logic [7:0]      e_tx[$];
  int              e_err = 0;
  logic [DACN-1:0] m_ovf = '0;

  always @(negedge clk) begin
    if (fifo_wr_en != '0) begin
      o_mask.push_back(fifo_wr_en);
      o_data.push_back(fifo_wr_data);
      o_cyc.push_back(cyc);
    end
    if (tx_valid) o_tx.push_back(tx_data);
    if (frame_err) o_err++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] csum_of(input logic [7:0] h,
                                         input logic [23:0] p);
    return h ^ p[23:16] ^ p[15:8] ^ p[7:0];
  endfunction

  // Frame-level rules: what one complete frame must produce.
  function automatic void model_frame(input logic [7:0] hdr,
                                      input logic [23:0] pay,
                                      input logic [DACN-1:0] full,
                                      input bit ck_ok);
    int cmd = int'(hdr[7:6]);
    int ch  = int'(hdr[5:0]);
    logic [DACN-1:0] tgt = '0;
    logic [DACN-1:0] drop;
    if (cmd == 2) begin
      e_tx.push_back(8'(full));
    end else if (cmd == 3 || (cmd == 0 && ch >= DACN)) begin
      e_tx.push_back(8'h15);
      e_err++;
    end else begin
      if (cmd == 1) tgt = '1;
      else          tgt[ch] = 1'b1;
      if (!ck_ok) begin
        e_tx.push_back(8'h15);
        e_err++;
      end else begin
        drop = tgt & full;
        if ((tgt & ~full) != '0) begin
          e_mask.push_back(tgt & ~full);
          e_data.push_back(pay);
        end
        m_ovf |= drop;
        e_tx.push_back(drop != '0 ? 8'h15 : 8'h06);
        if (drop != '0) e_err++;
      end
    end
  endfunction

  function automatic string obs_str();
    string s = "";
    foreach (o_mask[i]) s = {s, $sformatf("w%b:%h ", o_mask[i], o_data[i])};
    foreach (o_tx[i]) s = {s, $sformatf("t%h ", o_tx[i])};
    s = {s, $sformatf("e%0d o%b", o_err, overflow)};
    return s;
  endfunction

  function automatic string exp_str();
    string s = "";
    foreach (e_mask[i]) s = {s, $sformatf("w%b:%h ", e_mask[i], e_data[i])};
    foreach (e_tx[i]) s = {s, $sformatf("t%h ", e_tx[i])};
    s = {s, $sformatf("e%0d o%b", e_err, m_ovf)};
    return s;
  endfunction

  task automatic flush();
    o_mask.delete(); o_data.delete(); o_cyc.delete(); o_tx.delete();
    e_mask.delete(); e_data.delete(); e_tx.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [23:0] pay,
                            input int gap);
    put(hdr);
    if (hdr[7:6] != 2'b10) begin
      for (int i = 2; i >= 0; i--) begin
        idle(gap);
        put(pay[i*8 +: 8]);
      end
`ifdef ROUTER_CHECKSUM_EN
      idle(gap);
      put(csum_of(hdr, pay));
`endif
    end
  endtask

  task automatic wait_replies(input int n);
    int k = 0;
    while (o_tx.size() < n && k < 300) begin
      idle(1);
      k++;
    end
  endtask

  task automatic drive_frame(input logic [7:0] hdr, input logic [23:0] pay,
                             input logic [DACN-1:0] full, input int gap);
    fifo_full = full;
    model_frame(hdr, pay, full, 1'b1);
    send_frame(hdr, pay, gap);
    wait_replies(e_tx.size());
    idle(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    idle(3);
    total++;
    if (fifo_wr_en !== '0) begin
      bad++; $display("FAIL reset wr_en: got %b want 0", fifo_wr_en);
    end
    total++;
    if (fifo_wr_data !== '0) begin
      bad++; $display("FAIL reset wr_data: got %h want 0", fifo_wr_data);
    end
    total++;
    if (tx_data !== '0) begin
      bad++; $display("FAIL reset tx_data: got %h want 0", tx_data);
    end
    total++;
    if (tx_valid !== 1'b0) begin
      bad++; $display("FAIL reset tx_valid: got %b want 0", tx_valid);
    end
    total++;
    if (frame_err !== 1'b0) begin
      bad++; $display("FAIL reset frame_err: got %b want 0", frame_err);
    end
    total++;
    if (overflow !== '0) begin
      bad++; $display("FAIL reset overflow: got %b want 0", overflow);
    end
    reset_n = 1'b1;
    idle(2);
    flush();
  endtask

  task automatic test_write();
    drive_frame(8'h01, 24'h123456, 2'b00, 0);
    total++;
    if (o_cyc.size() != 1 || o_cyc[0] != last_cyc) begin
      bad++;
      $display("FAIL write latency: got cycle %0d (n=%0d) want %0d",
               o_cyc.size() > 0 ? o_cyc[0] : -1, o_cyc.size(), last_cyc);
    end
    total++;
    if (obs_str() != exp_str()) begin
      bad++; $display("FAIL write: got %s want %s", obs_str(), exp_str());
    end
    flush();
  endtask

  task automatic test_broadcast();
    drive_frame(8'h40, 24'hABCDEF, 2'b00, 0);
    total++;
    if (obs_str() != exp_str()) begin
      bad++; $display("FAIL bcast: got %s want %s", obs_str(), exp_str());
    end
    flush();
    drive_frame(8'h40, 24'hABCDEF, 2'b01, 1);
    total++;
    if (obs_str() != exp_str()) begin
      bad++; $display("FAIL bcast_full: got %s want %s", obs_str(), exp_str());
    end
    flush();
    fifo_full = '0;
  endtask

  task automatic test_bad_channel();
    drive_frame(8'h05, 24'h777777, 2'b00, 0);
    drive_frame(8'hC1, 24'h0F0F0F, 2'b00, 1);
    drive_frame(8'h00, 24'h000001, 2'b00, 0);
    total++;
    if (obs_str() != exp_str()) begin
      bad++; $display("FAIL bad_chan: got %s want %s", obs_str(), exp_str());
    end
    flush();
  endtask

  task automatic test_status_skid();
    int seen = 0;
    fifo_full = 2'b10;
    tx_busy   = 1'b1;
    model_frame(8'h80, 24'h0, 2'b10, 1'b1);
    put(8'h80);
    idle(3);
    put(8'h00);
    put(8'h40);
    e_err++;
    repeat (45) begin
      idle(1);
      if (tx_valid) seen++;
    end
    total++;
    if (seen != 0 || o_tx.size() != 0) begin
      bad++;
      $display("FAIL busy_hold: got %0d replies while busy want 0",
               seen + o_tx.size());
    end
    tx_busy = 1'b0;
    model_frame(8'h00, 24'h0A0B0C, 2'b10, 1'b1);
    wait_replies(1);
    put(8'h0A);
    put(8'h0B);
    put(8'h0C);
`ifdef ROUTER_CHECKSUM_EN
    put(csum_of(8'h00, 24'h0A0B0C));
`endif
    wait_replies(2);
    idle(2);
    total++;
    if (obs_str() != exp_str()) begin
      bad++; $display("FAIL status_skid: got %s want %s", obs_str(), exp_str());
    end
    flush();
    fifo_full = '0;
  endtask

  task automatic test_timeout();
    fifo_full = '0;
    put(8'h00);
    put(8'h11);
    idle(TMO - 20);
    total++;
    if (o_err != e_err || o_mask.size() != 0) begin
      bad++;
      $display("FAIL timeout_early: got err=%0d writes=%0d want err=%0d writes=0",
               o_err, o_mask.size(), e_err);
    end
    idle(40);
    e_err++;
    total++;
    if (obs_str() != exp_str()) begin
      bad++; $display("FAIL timeout: got %s want %s", obs_str(), exp_str());
    end
    flush();
    drive_frame(8'h01, 24'h0C0FFE, 2'b00, 0);
    total++;
    if (obs_str() != exp_str()) begin
      bad++; $display("FAIL after_timeout: got %s want %s", obs_str(), exp_str());
    end
    flush();
  endtask

  task automatic test_reset_mid();
    fifo_full = '0;
    put(8'h01);
    put(8'h22);
    idle(1);
    reset_n = 1'b0;
    #1;
    total++;
    if ({fifo_wr_en, fifo_wr_data, tx_data, tx_valid, frame_err, overflow}
        !== '0) begin
      bad++;
      $display("FAIL reset_mid: got wr=%b d=%h tx=%h v=%b e=%b ov=%b want 0",
               fifo_wr_en, fifo_wr_data, tx_data, tx_valid, frame_err, overflow);
    end
    m_ovf = '0;
    idle(3);
    reset_n = 1'b1;
    idle(2);
    drive_frame(8'h01, 24'h654321, 2'b00, 0);
    total++;
    if (obs_str() != exp_str()) begin
      bad++; $display("FAIL after_reset: got %s want %s", obs_str(), exp_str());
    end
    flush();
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [7:0] hdr;
      hdr = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
      drive_frame(hdr, 24'($urandom), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 2));
      total++;
      if (obs_str() != exp_str()) begin
        bad++;
        $display("FAIL random %0d hdr=%h: got %s want %s",
                 n, hdr, obs_str(), exp_str());
      end
      flush();
    end
  endtask

  task automatic test_back_to_back();
    fifo_full = 2'($urandom_range(0, 3));
    for (int n = 0; n < 6; n++) begin
      logic [7:0]  hdr;
      logic [23:0] pay;
      hdr = {2'($urandom_range(0, 2)), 6'($urandom_range(0, 2))};
      pay = 24'($urandom);
      model_frame(hdr, pay, fifo_full, 1'b1);
      send_frame(hdr, pay, 0);
      idle(2);
    end
    wait_replies(e_tx.size());
    idle(2);
    total++;
    if (obs_str() != exp_str()) begin
      bad++; $display("FAIL back_to_back: got %s want %s", obs_str(), exp_str());
    end
    flush();
    fifo_full = '0;
  endtask

`ifdef ROUTER_CHECKSUM_EN
  task automatic test_checksum();
    fifo_full = '0;
    model_frame(8'h01, 24'h123456, 2'b00, 1'b1);
    put(8'h01); put(8'h12); put(8'h34); put(8'h56);
    put(csum_of(8'h01, 24'h123456));
    wait_replies(1);
    idle(2);
    total++;
    if (obs_str() != exp_str()) begin
      bad++; $display("FAIL csum_good: got %s want %s", obs_str(), exp_str());
    end
    flush();
    model_frame(8'h01, 24'h123456, 2'b00, 1'b0);
    put(8'h01); put(8'h12); put(8'h34); put(8'h56);
    put(8'h00);
    wait_replies(1);
    idle(2);
    total++;
    if (obs_str() != exp_str()) begin
      bad++; $display("FAIL csum_bad: got %s want %s", obs_str(), exp_str());
    end
    flush();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_broadcast();
    test_bad_channel();
    test_status_skid();
`ifdef ROUTER_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
